restoring_divider_6by3: RTL and testbench

Sequential restoring divider that inverts the 3×3 array multiplier: it takes a 6-bit dividend (the multiplier's product width) and a 3-bit divisor and produces a 6-bit quotient and 3-bit remainder. It sits beside the adder/multiplier datapath in the arithmetic unit. It resolves one quotient bit per clock under a start/busy/done handshake, and it flags divide-by-zero.

---
 rtl/restoring_divider_6by3.sv | 154 +++++++++++++++
 tb/tb_restoring_divider_6by3.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider_6by3.sv
// ---------------------------------------------------------------------------
// restoring_divider_6by3
//
// Sequential unsigned restoring divider. It is the inverse of the 3x3 array
// multiplier: a 6-bit dividend divided by a 3-bit divisor gives a 6-bit
// quotient and a 3-bit remainder, one quotient bit per clock.
//
// Ports:
//   clk          clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   start        request, sampled only while the divider is idle
//   dividend     numerator, captured on the accepted start edge
//   divisor      denominator, captured on the accepted start edge
//   busy         high while iterating
//   done         one-cycle pulse when the result registers update
//   quotient     registered quotient of the last completed operation
//   remainder    registered remainder of the last completed operation
//   div_by_zero  registered divide-by-zero flag of the last operation
// ---------------------------------------------------------------------------
module restoring_divider_6by3 #(
    parameter int DIVIDEND_W = 6,
    parameter int DIVISOR_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                state;
    state_t                state_next;

    logic [DIVIDEND_W-1:0] dvd_shift;
    logic [DIVISOR_W-1:0]  dsr_reg;
    // After every restoring step the partial remainder is below the divisor,
    // so its top bit is always zero and only DIVISOR_W bits need storing.
    // The shifted value used for the compare keeps the full DIVISOR_W+1 bits.
    logic [DIVISOR_W-1:0]  part_rem;
    // The last quotient bit goes straight into the result register, so the
    // working quotient only ever holds DIVIDEND_W-1 bits.
    logic [DIVIDEND_W-2:0] quo_work;
    logic [CNT_W-1:0]      count;
    logic                  zero_pending;

    logic                  accept;
    logic                  accept_run;
    logic                  accept_zero;
    logic                  last_step;
    logic [DIVISOR_W:0]    pr_shift;
    logic [DIVISOR_W:0]    pr_step;
    logic                  q_bit;

    // A start is only taken when idle and not finishing a divide-by-zero,
    // so a request in that one pending cycle cannot be half-accepted.
    assign accept      = (state == IDLE) && start && !zero_pending;
    assign accept_run  = accept && (divisor != '0);
    assign accept_zero = accept && (divisor == '0);
    assign last_step   = (state == RUN) && (count == CNT_W'(1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept_run) state_next = RUN;
            RUN:  if (last_step)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = 1'b0;
        if (state == RUN) busy = 1'b1;
    end

    // One restoring step: bring in the next dividend bit, trial-subtract,
    // and keep the difference only when it does not go negative.
    always_comb begin
        pr_shift = {part_rem, dvd_shift[DIVIDEND_W-1]};
        q_bit    = (pr_shift >= {1'b0, dsr_reg});
        pr_step  = pr_shift;
        if (q_bit) pr_step = pr_shift - {1'b0, dsr_reg};
    end

    // Working registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_shift <= '0;
            dsr_reg   <= '0;
            part_rem  <= '0;
            quo_work  <= '0;
            count     <= '0;
        end else if (accept) begin
            dvd_shift <= dividend;
            dsr_reg   <= divisor;
            part_rem  <= '0;
            quo_work  <= '0;
            count     <= CNT_W'(DIVIDEND_W);
        end else if (state == RUN) begin
            dvd_shift <= dvd_shift << 1;
            part_rem  <= pr_step[DIVISOR_W-1:0];
            quo_work  <= {quo_work[DIVIDEND_W-3:0], q_bit};
            count     <= count - CNT_W'(1);
        end
    end

    // Result registers: they only move at completion and hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done         <= 1'b0;
            quotient     <= '0;
            remainder    <= '0;
            div_by_zero  <= 1'b0;
            zero_pending <= 1'b0;
        end else begin
            done         <= 1'b0;
            zero_pending <= accept_zero;
            if (last_step) begin
                quotient    <= {quo_work, q_bit};
                remainder   <= pr_step[DIVISOR_W-1:0];
                div_by_zero <= 1'b0;
                done        <= 1'b1;
            end else if (zero_pending) begin
                quotient    <= '1;
                remainder   <= '0;
                div_by_zero <= 1'b1;
                done        <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_restoring_divider_6by3.sv
// ---------------------------------------------------------------------------
// tb_restoring_divider_6by3
//
// Scoreboard bench for restoring_divider_6by3. Each accepted request pushes
// its operands and the cycle its done pulse must appear in; the monitor pops
// on every done and compares result, flag, latency and the division
// invariant, and checks that results hold between completions.
// ---------------------------------------------------------------------------
module tb_restoring_divider_6by3;

    localparam int DW = 6;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [SW-1:0] divisor = '0;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [SW-1:0] remainder;
    logic          div_by_zero;

    restoring_divider_6by3 #(
        .DIVIDEND_W(DW),
        .DIVISOR_W (SW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        int dvd;
        int dsr;
        int done_cycle;
    } exp_t;

    exp_t sb[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   last_q = 0;
    int   last_r = 0;
    int   last_z = 0;
    exp_t mon_e;
    int   exp_q;
    int   exp_r;
    int   exp_z;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one request; called while the divider is ready to accept.
    task automatic applyStimulus(input int a, input int b);
        exp_t e;
        e.dvd        = a;
        e.dsr        = b;
        e.done_cycle = cycle + 1 + ((b == 0) ? 1 : DW);
        dividend     = a[DW-1:0];
        divisor      = b[SW-1:0];
        start        = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom_range(63, 0);
        divisor  = $urandom_range(7, 0);
    endtask

    task automatic waitIdle(input int max_cycles);
        int n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (sb.size() != 0) begin
            checkOutput("timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    // Monitor: score every done pulse, otherwise results must hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_q = 0;
            last_r = 0;
            last_z = 0;
        end else if (done) begin
            checkOutput("busy_done_overlap", busy, 0);
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.dsr == 0) begin
                    exp_q = 63;
                    exp_r = 0;
                    exp_z = 1;
                end else begin
                    exp_q = mon_e.dvd / mon_e.dsr;
                    exp_r = mon_e.dvd % mon_e.dsr;
                    exp_z = 0;
                end
                checkOutput("quotient", quotient, exp_q);
                checkOutput("remainder", remainder, exp_r);
                checkOutput("div_by_zero", div_by_zero, exp_z);
                checkOutput("latency", cycle, mon_e.done_cycle);
                if (mon_e.dsr != 0) begin
                    checkOutput("invariant", quotient * mon_e.dsr + remainder, mon_e.dvd);
                    checkOutput("rem_lt_dsr", remainder < mon_e.dsr, 1);
                end
            end
            last_q = quotient;
            last_r = remainder;
            last_z = div_by_zero;
        end else begin
            checkOutput("hold_quotient", quotient, last_q);
            checkOutput("hold_remainder", remainder, last_r);
            checkOutput("hold_dbz", div_by_zero, last_z);
        end
    end

    initial begin
        int n;

        repeat (2) @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_quotient", quotient, 0);
        checkOutput("reset_remainder", remainder, 0);
        checkOutput("reset_dbz", div_by_zero, 0);
        #1 rst_n = 1'b1;

        // Basic division, busy immediately after the accepting edge
        applyStimulus(42, 5);
        checkOutput("busy_after_start", busy, 1);
        waitIdle(20);

        applyStimulus(63, 7);
        waitIdle(20);
        applyStimulus(7, 7);
        waitIdle(20);
        applyStimulus(0, 3);
        waitIdle(20);

        // Divide by zero, then a normal division clears the flag
        applyStimulus(5, 0);
        checkOutput("dbz_busy", busy, 0);
        checkOutput("dbz_done_early", done, 0);
        waitIdle(20);
        applyStimulus(12, 4);
        waitIdle(20);

        // Start while busy is ignored and not queued
        applyStimulus(63, 1);
        repeat (2) @(negedge clk);
        #1;
        dividend = 6'd10;
        divisor  = 3'd3;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waitIdle(20);
        repeat (10) @(negedge clk);
        #2;

        // Back-to-back start in the done cycle
        applyStimulus(42, 5);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("b2b_done_seen", done, 1);
        #1 applyStimulus(17, 4);
        waitIdle(20);

        // Reset mid-run aborts with no done pulse
        applyStimulus(63, 2);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_quotient", quotient, 0);
        checkOutput("abort_remainder", remainder, 0);
        checkOutput("abort_dbz", div_by_zero, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(9, 2);
        waitIdle(20);

        // Full operand sweep
        for (int a = 0; a < 64; a++) begin
            for (int b = 0; b < 8; b++) begin
                applyStimulus(a, b);
                waitIdle(20);
            end
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
